mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/codes_pkg.sv | 53 +++++
 rtl/load_align.sv | 51 +++++
 rtl/mem_stage.sv | 207 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/codes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : codes_pkg
// Description : Shared types and helpers for the memory stage: datapath
//               width, access-size encoding, FSM state encoding, byte-enable
//               and alignment helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package codes_pkg;

    localparam int DATA_WIDTH = 64;

    // Access size of a load/store.
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_t;

    // Memory-stage FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Byte-enable pattern for an access at lane 0.
    function automatic logic [7:0] size_be(input mem_size_t sz);
        logic [7:0] be;
        case (sz)
            SZ_B:    be = 8'h01;
            SZ_H:    be = 8'h03;
            SZ_W:    be = 8'h0F;
            default: be = 8'hFF;
        endcase
        return be;
    endfunction

    // True when the access is not naturally aligned to its size.
    function automatic logic is_misaligned(input mem_size_t sz, input logic [2:0] off);
        logic mis;
        case (sz)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = off[0];
            SZ_W:    mis = |off[1:0];
            default: mis = |off;
        endcase
        return mis;
    endfunction

endpackage : codes_pkg
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combinational load-data extraction. Shifts the doubleword
//               read data right to the addressed byte lane, keeps the low
//               8/16/32/64 bits and sign- or zero-extends them.
// Ports       : rdata       - raw doubleword from data memory
//               offset      - byte offset within the doubleword
//               size        - access size
//               is_unsigned - zero-extend instead of sign-extend
//               data        - extracted, extended load value
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import codes_pkg::*;
#(
    parameter int DATA_WIDTH = codes_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [2:0]            offset,
    input  mem_size_t             size,
    input  logic                  is_unsigned,
    output logic [DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] w_shifted;
    logic                  w_sign;

    always_comb begin
        w_shifted = rdata >> {offset, 3'b000};
        w_sign    = 1'b0;
        data      = w_shifted;
        case (size)
            SZ_B: begin
                w_sign = ~is_unsigned & w_shifted[7];
                data   = {{(DATA_WIDTH-8){w_sign}}, w_shifted[7:0]};
            end
            SZ_H: begin
                w_sign = ~is_unsigned & w_shifted[15];
                data   = {{(DATA_WIDTH-16){w_sign}}, w_shifted[15:0]};
            end
            SZ_W: begin
                w_sign = ~is_unsigned & w_shifted[31];
                data   = {{(DATA_WIDTH-32){w_sign}}, w_shifted[31:0]};
            end
            default: data = w_shifted;
        endcase
    end

endmodule : load_align
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Pipeline memory stage. ALU results pass straight through
//               with one cycle of latency; loads and stores are issued on a
//               req/gnt data-memory port and loads wait for rvalid.
//               Optional macro MEM_MISALIGN_TRAP_EN: misaligned accesses are
//               not issued and instead produce a one-cycle misalign pulse.
// Ports       : clk, rst_n                    - clock, async active-low reset
//               in_valid/in_ready             - EX-side handshake
//               alu_result, store_data,
//               mem_read, mem_write, mem_size,
//               mem_unsigned, rd_in,
//               reg_write_in                  - EX result and op controls
//               dmem_req/we/addr/wdata/be     - data-memory request
//               dmem_gnt, dmem_rvalid,
//               dmem_rdata                    - data-memory response
//               out_valid, out_data, rd_out,
//               reg_write_out                 - writeback result pulse
//               stall                         - input held off this cycle
//               misalign                      - misaligned-access trap pulse
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import codes_pkg::*;
#(
    parameter int DATA_WIDTH = codes_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            mem_size,
    input  logic                  mem_unsigned,
    input  logic [4:0]            rd_in,
    input  logic                  reg_write_in,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [7:0]            dmem_be,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [4:0]            rd_out,
    output logic                  reg_write_out,
    output logic                  stall,
    output logic                  misalign
);

    // ------------------------------------------------------------------
    // State and captured request
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_addr;      // full alu_result, low bits = lane offset
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [7:0]            r_be;
    logic                  r_we;
    mem_size_t             r_size;
    logic                  r_unsigned;
    logic [4:0]            r_rd;
    logic                  r_reg_write;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [4:0]            r_rd_out;
    logic                  r_reg_write_out;
    logic                  r_misalign;

    // ------------------------------------------------------------------
    // Input decode
    // ------------------------------------------------------------------
    mem_size_t             w_size;
    logic [2:0]            w_off;
    logic                  w_is_mem;
    logic                  w_trap;
    logic [DATA_WIDTH-1:0] w_load_data;

    assign w_size   = mem_size_t'(mem_size);
    assign w_off    = alu_result[2:0];
    assign w_is_mem = mem_read | mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_trap = w_is_mem & is_misaligned(w_size, w_off);
`else
    assign w_trap = 1'b0;
`endif

    load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align (
        .rdata       (dmem_rdata),
        .offset      (r_addr[2:0]),
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .data        (w_load_data)
    );

    // ------------------------------------------------------------------
    // FSM and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_be            <= '0;
            r_we            <= 1'b0;
            r_size          <= SZ_B;
            r_unsigned      <= 1'b0;
            r_rd            <= '0;
            r_reg_write     <= 1'b0;
            r_out_valid     <= 1'b0;
            r_out_data      <= '0;
            r_rd_out        <= '0;
            r_reg_write_out <= 1'b0;
            r_misalign      <= 1'b0;
        end else begin
            // Result and trap outputs are single-cycle pulses.
            r_out_valid <= 1'b0;
            r_misalign  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (!w_is_mem) begin
                            r_out_valid     <= 1'b1;
                            r_out_data      <= alu_result;
                            r_rd_out        <= rd_in;
                            r_reg_write_out <= reg_write_in;
                        end else if (w_trap) begin
                            r_out_valid     <= 1'b1;
                            r_misalign      <= 1'b1;
                            r_out_data      <= alu_result;
                            r_rd_out        <= rd_in;
                            r_reg_write_out <= 1'b0;
                        end else begin
                            r_addr      <= alu_result;
                            r_wdata     <= store_data << {w_off, 3'b000};
                            // Shift in 8 bits so lanes past byte 7 fall off.
                            r_be        <= size_be(w_size) << w_off;
                            // A read+write op is treated as a store.
                            r_we        <= mem_write;
                            r_size      <= w_size;
                            r_unsigned  <= mem_unsigned;
                            r_rd        <= rd_in;
                            r_reg_write <= reg_write_in;
                            r_state     <= ST_REQ;
                        end
                    end
                end

                ST_REQ: begin
                    if (dmem_gnt) begin
                        if (r_we) begin
                            r_out_valid     <= 1'b1;
                            r_out_data      <= r_addr;
                            r_rd_out        <= r_rd;
                            r_reg_write_out <= 1'b0;
                            r_state         <= ST_IDLE;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (dmem_rvalid) begin
                        r_out_valid     <= 1'b1;
                        r_out_data      <= w_load_data;
                        r_rd_out        <= r_rd;
                        r_reg_write_out <= r_reg_write;
                        r_state         <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs; the request bus reads as zero whenever no request is open.
    // ------------------------------------------------------------------
    assign in_ready      = (r_state == ST_IDLE);
    assign stall         = in_valid & ~in_ready;

    assign dmem_req      = (r_state == ST_REQ);
    assign dmem_we       = dmem_req & r_we;
    assign dmem_addr     = dmem_req ? {r_addr[DATA_WIDTH-1:3], 3'b000} : '0;
    assign dmem_wdata    = dmem_req ? r_wdata : '0;
    assign dmem_be       = dmem_req ? r_be : 8'h00;

    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign rd_out        = r_rd_out;
    assign reg_write_out = r_reg_write_out;
    assign misalign      = r_misalign;

endmodule : mem_stage
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage. Expected writeback pulses
//               are queued as stimulus is driven and compared when out_valid
//               fires; request-bus fields and latencies are checked inline.
//               Build with MEM_MISALIGN_TRAP_EN to exercise the trap variant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
    import codes_pkg::*;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] alu_result;
    logic [W-1:0] store_data;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_size;
    logic         mem_unsigned;
    logic [4:0]   rd_in;
    logic         reg_write_in;
    logic         dmem_req;
    logic         dmem_we;
    logic [W-1:0] dmem_addr;
    logic [W-1:0] dmem_wdata;
    logic [7:0]   dmem_be;
    logic         dmem_gnt;
    logic         dmem_rvalid;
    logic [W-1:0] dmem_rdata;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [4:0]   rd_out;
    logic         reg_write_out;
    logic         stall;
    logic         misalign;

    int checks      = 0;
    int failures    = 0;
    int req_cycles  = 0;

    typedef struct {
        logic [W-1:0] data;
        logic [4:0]   rd;
        logic         rw;
        logic         mis;
    } exp_t;

    exp_t sb[$];

    mem_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_result    (alu_result),
        .store_data    (store_data),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_size      (mem_size),
        .mem_unsigned  (mem_unsigned),
        .rd_in         (rd_in),
        .reg_write_in  (reg_write_in),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_be       (dmem_be),
        .dmem_gnt      (dmem_gnt),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .rd_out        (rd_out),
        .reg_write_out (reg_write_out),
        .stall         (stall),
        .misalign      (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every out_valid pulse must match the oldest entry.
    always @(negedge clk) begin
        if (dmem_req) req_cycles++;
        if (rst_n && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out_valid: got out_data=%h rw=%b, required no pulse",
                         out_data, reg_write_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_data !== e.data || reg_write_out !== e.rw || misalign !== e.mis ||
                    (e.rw && rd_out !== e.rd)) begin
                    failures++;
                    $display("FAIL out_pulse: got data=%h rd=%0d rw=%b mis=%b, required data=%h rd=%0d rw=%b mis=%b",
                             out_data, rd_out, reg_write_out, misalign, e.data, e.rd, e.rw, e.mis);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_unsigned = 1'b0;
    endtask

    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] s,
                            input logic rd_op, input logic wr_op, input logic [1:0] sz,
                            input logic uns, input logic [4:0] rd, input logic rw);
        alu_result   = a;
        store_data   = s;
        mem_read     = rd_op;
        mem_write    = wr_op;
        mem_size     = sz;
        mem_unsigned = uns;
        rd_in        = rd;
        reg_write_in = rw;
        in_valid     = 1'b1;
    endtask

    // Wait (bounded) until all expected pulses have been seen.
    task automatic wait_drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_%s: got %0d pulses outstanding, required 0", name, sb.size());
            sb.delete();
        end
        step();
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        idle_inputs();
        alu_result  = '0;
        store_data  = '0;
        mem_size    = 2'd0;
        rd_in       = '0;
        reg_write_in = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || dmem_req !== 1'b0 || misalign !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got in_ready=%b out_valid=%b req=%b mis=%b, required 1 0 0 0",
                     in_ready, out_valid, dmem_req, misalign);
        end
        checks++;
        if (out_data !== '0 || rd_out !== '0 || reg_write_out !== 1'b0 || dmem_be !== 8'h00 ||
            dmem_addr !== '0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: got data=%h rd=%0d rw=%b be=%h addr=%h stall=%b, required all zero",
                     out_data, rd_out, reg_write_out, dmem_be, dmem_addr, stall);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
    endtask

    task automatic test_passthrough();
        int r0;
        r0 = req_cycles;
        drive_op(64'h1234, 64'h0, 1'b0, 1'b0, SZ_D, 1'b0, 5'd5, 1'b1);
        sb.push_back('{data: 64'h1234, rd: 5'd5, rw: 1'b1, mis: 1'b0});
        step();
        idle_inputs();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL pass_latency: got out_valid=%b in_ready=%b, required 1 1", out_valid, in_ready);
        end
        wait_drain("pass");
        checks++;
        if (req_cycles != r0) begin
            failures++;
            $display("FAIL pass_no_req: got %0d req cycles, required 0", req_cycles - r0);
        end
    endtask

    task automatic test_back_to_back();
        drive_op(64'h1111, 64'h0, 1'b0, 1'b0, SZ_D, 1'b0, 5'd1, 1'b1);
        sb.push_back('{data: 64'h1111, rd: 5'd1, rw: 1'b1, mis: 1'b0});
        step();
        drive_op(64'h2222, 64'h0, 1'b0, 1'b0, SZ_D, 1'b0, 5'd2, 1'b0);
        sb.push_back('{data: 64'h2222, rd: 5'd2, rw: 1'b0, mis: 1'b0});
        step();
        idle_inputs();
        wait_drain("b2b");
    endtask

    task automatic test_store(input string name, input logic [W-1:0] a, input logic [W-1:0] s,
                              input logic [1:0] sz, input logic also_read, input int gnt_delay,
                              input logic [7:0] exp_be, input logic [W-1:0] exp_wdata);
        logic [W-1:0] exp_addr;
        exp_addr = {a[W-1:3], 3'b000};
        drive_op(a, s, also_read, 1'b1, sz, 1'b0, 5'd7, 1'b1);
        sb.push_back('{data: a, rd: 5'd7, rw: 1'b0, mis: 1'b0});
        step();
        idle_inputs();
        for (int i = 0; i <= gnt_delay; i++) begin
            dmem_gnt = (i == gnt_delay);
            if (i == 0 && gnt_delay > 0) in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== exp_addr ||
                dmem_be !== exp_be || dmem_wdata !== exp_wdata) begin
                failures++;
                $display("FAIL %s_req%0d: got req=%b we=%b addr=%h be=%h wdata=%h, required 1 1 %h %h %h",
                         name, i, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                         exp_addr, exp_be, exp_wdata);
            end
            if (i == 0 && gnt_delay > 0) begin
                checks++;
                if (stall !== 1'b1 || in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_stall: got stall=%b in_ready=%b, required 1 0", name, stall, in_ready);
                end
                in_valid = 1'b0;
            end
            step();
        end
        dmem_gnt = 1'b0;
        wait_drain(name);
    endtask

    task automatic test_load(input string name, input logic [W-1:0] a, input logic [1:0] sz,
                             input logic uns, input int gnt_delay, input logic [W-1:0] rdata,
                             input logic [7:0] exp_be, input logic [W-1:0] exp_data);
        logic [W-1:0] exp_addr;
        exp_addr = {a[W-1:3], 3'b000};
        drive_op(a, 64'h0, 1'b1, 1'b0, sz, uns, 5'd11, 1'b1);
        sb.push_back('{data: exp_data, rd: 5'd11, rw: 1'b1, mis: 1'b0});
        step();
        idle_inputs();
        // Stray read data while the request is still open must be ignored.
        dmem_rvalid = 1'b1;
        dmem_rdata  = ~rdata;
        for (int i = 0; i <= gnt_delay; i++) begin
            dmem_gnt = (i == gnt_delay);
            @(negedge clk);
            checks++;
            if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== exp_addr || dmem_be !== exp_be) begin
                failures++;
                $display("FAIL %s_req%0d: got req=%b we=%b addr=%h be=%h, required 1 0 %h %h",
                         name, i, dmem_req, dmem_we, dmem_addr, dmem_be, exp_addr, exp_be);
            end
            step();
        end
        dmem_gnt   = 1'b0;
        dmem_rdata = rdata;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL %s_wait: got out_valid=%b req=%b, required 0 0", name, out_valid, dmem_req);
        end
        step();
        dmem_rvalid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_latency: got out_valid=%b, required 1", name, out_valid);
        end
        wait_drain(name);
    endtask

    task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
        int r0;
        r0 = req_cycles;
        drive_op(64'h3002, 64'h0, 1'b1, 1'b0, SZ_W, 1'b0, 5'd9, 1'b1);
        sb.push_back('{data: 64'h3002, rd: 5'd9, rw: 1'b0, mis: 1'b1});
        step();
        drive_op(64'h1001, 64'h55, 1'b0, 1'b1, SZ_H, 1'b0, 5'd9, 1'b0);
        sb.push_back('{data: 64'h1001, rd: 5'd9, rw: 1'b0, mis: 1'b1});
        step();
        idle_inputs();
        step();
        checks++;
        if (misalign !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL trap_pulse: got misalign=%b out_valid=%b, required 0 0", misalign, out_valid);
        end
        wait_drain("trap");
        checks++;
        if (req_cycles != r0) begin
            failures++;
            $display("FAIL trap_no_req: got %0d req cycles, required 0", req_cycles - r0);
        end
`else
        test_load("lw_mis", 64'h3002, SZ_W, 1'b0, 0, 64'h0000_1122_3344_0000, 8'h3C, 64'h0000_0000_1122_3344);
        test_store("sd_mis", 64'h1001, 64'h1122_3344_5566_7788, SZ_D, 1'b0, 1, 8'hFE, 64'h2233_4455_6677_8800);
        checks++;
        if (misalign !== 1'b0) begin
            failures++;
            $display("FAIL mis_tied: got misalign=%b, required 0", misalign);
        end
`endif
    endtask

    task automatic test_reset_mid();
        drive_op(64'h2000, 64'h0, 1'b1, 1'b0, SZ_D, 1'b0, 5'd3, 1'b1);
        step();
        idle_inputs();
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_async: got in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        dmem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || dmem_req !== 1'b0) begin
                failures++;
                $display("FAIL rst_mid%0d: got out_valid=%b in_ready=%b req=%b, required 0 1 0",
                         i, out_valid, in_ready, dmem_req);
            end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_back_to_back();
        test_store("sb",  64'h1003, 64'hAB, SZ_B, 1'b0, 3, 8'h08, 64'h0000_0000_AB00_0000);
        test_store("sh",  64'h1006, 64'h1234, SZ_H, 1'b0, 0, 8'hC0, 64'h1234_0000_0000_0000);
        test_store("sw",  64'h1004, 64'hCAFE_F00D, SZ_W, 1'b1, 1, 8'hF0, 64'hCAFE_F00D_0000_0000);
        test_store("sd",  64'h1000, 64'h0123_4567_89AB_CDEF, SZ_D, 1'b0, 0, 8'hFF, 64'h0123_4567_89AB_CDEF);
        test_load("lb_s",  64'h2005, SZ_B, 1'b0, 0, 64'h0000_80FF_0000_0000, 8'h20, 64'hFFFF_FFFF_FFFF_FF80);
        test_load("lb_u",  64'h2005, SZ_B, 1'b1, 2, 64'h0000_80FF_0000_0000, 8'h20, 64'h0000_0000_0000_0080);
        test_load("lh_s",  64'h2006, SZ_H, 1'b0, 1, 64'h8001_0000_0000_0000, 8'hC0, 64'hFFFF_FFFF_FFFF_8001);
        test_load("lw_u",  64'h2004, SZ_W, 1'b1, 0, 64'hDEAD_BEEF_1234_5678, 8'hF0, 64'h0000_0000_DEAD_BEEF);
        test_load("lw_s",  64'h2004, SZ_W, 1'b0, 0, 64'hDEAD_BEEF_1234_5678, 8'hF0, 64'hFFFF_FFFF_DEAD_BEEF);
        test_load("ld",    64'h2008, SZ_D, 1'b0, 0, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF);
        test_misalign();
        test_reset_mid();
        test_passthrough();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_stage
`default_nettype wire
